terminal_requisitante_acesso: RTL and testbench

//  Terminal-side initiator for the access controller. Debounces the user's send button.

---
 rtl/pbl_pkg.sv | 22 ++
 rtl/filtro_botao.sv | 51 +++++
 rtl/terminal_requisitante_acesso.sv | 131 +++++++++++++
 tb/tb_terminal_requisitante_acesso.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbl_pkg.sv
// Shared definitions for the access-controller terminals: FSM encoding and STATUS codes.
// Also holds the odd-parity helper used by the optional parity output.
package pbl_pkg;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      ENVIA  = 2'd1,
      LIBERA = 2'd2,
      RECUA  = 2'd3
   } estado_t;

   localparam logic [1:0] ST_NENHUM   = 2'b00;
   localparam logic [1:0] ST_LIBERADO = 2'b01;
   localparam logic [1:0] ST_NEGADO   = 2'b10;
   localparam logic [1:0] ST_TEMPO    = 2'b11;

   // Odd parity: result makes the total count of ones (word + bit) odd.
   function automatic logic paridade_impar(input logic [5:0] palavra);
      return ~^palavra;
   endfunction

endpackage

// File: rtl/filtro_botao.sv
// Send-button conditioner: 2-FF synchronizer, debounce counter, rising-edge detector.
// PRESS is a registered 1-cycle pulse issued when a new high level is accepted.
module filtro_botao #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic BTN_IN,
   output logic PRESS
);

   localparam int            CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic          sinc_a;
   logic          sinc_b;
   logic          estavel;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sinc_a <= 1'b0;
         sinc_b <= 1'b0;
      end else begin
         sinc_a <= BTN_IN;
         sinc_b <= sinc_a;
      end
   end

   // The counter tracks consecutive samples that disagree with the accepted level;
   // a sample matching the accepted level means the run was broken, so it restarts.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt     <= '0;
         estavel <= 1'b0;
         PRESS   <= 1'b0;
      end else begin
         PRESS <= 1'b0;
         if (sinc_b == estavel) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            cnt     <= '0;
            estavel <= sinc_b;
            PRESS   <= sinc_b;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/terminal_requisitante_acesso.sv
// Terminal initiator: latches HH/B on a debounced press and delivers it over REQ/ACK/NEG with retries.
// Optional build macro PARIDADE_EN adds REQ_PAR, the odd parity of {REQ_HH, REQ_B}.
module terminal_requisitante_acesso
   import pbl_pkg::*;
#(
   parameter int DEB_CYCLES     = 50000,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_RETRY      = 3
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] HH,
   input  logic [1:0] B,
   input  logic       BTN_ENVIA,
   input  logic       ACK,
   input  logic       NEG,
   output logic       REQ,
   output logic [3:0] REQ_HH,
   output logic [1:0] REQ_B,
   output logic       OCUPADO,
   output logic [1:0] STATUS
`ifdef PARIDADE_EN
  ,output logic       REQ_PAR
`endif
);

   localparam int            TMW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMW-1:0] TMR_MAX = TMW'(TIMEOUT_CYCLES - 1);
   localparam int            TW       = $clog2(MAX_RETRY + 1);
   localparam logic [TW-1:0] TENT_MAX = TW'(MAX_RETRY);

   estado_t        estado;
   estado_t        prox;
   logic           press;
   logic [TMW-1:0] timer;
   logic [TW-1:0]  tent;

   filtro_botao #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_filtro (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .BTN_IN (BTN_ENVIA),
      .PRESS  (press)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         estado <= OCIOSO;
      end else begin
         estado <= prox;
      end
   end

   // A response in the expiry cycle is checked first, so it wins over the timeout.
   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO: if (press) prox = ENVIA;
         ENVIA: begin
            if (NEG || ACK) begin
               prox = LIBERA;
            end else if (timer == TMR_MAX) begin
               prox = RECUA;
            end
         end
         LIBERA: if (!ACK && !NEG) prox = OCIOSO;
         RECUA:  prox = (tent < TENT_MAX) ? ENVIA : OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   // REQ comes straight from the state flop so an async reset drops it immediately.
   always_comb begin
      REQ     = (estado == ENVIA);
      OCUPADO = (estado != OCIOSO);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         REQ_HH  <= '0;
         REQ_B   <= '0;
         STATUS  <= ST_NENHUM;
         tent    <= '0;
`ifdef PARIDADE_EN
         REQ_PAR <= 1'b1;
`endif
      end else begin
         case (estado)
            OCIOSO: begin
               if (press) begin
                  REQ_HH  <= HH;
                  REQ_B   <= B;
                  STATUS  <= ST_NENHUM;
                  tent    <= TW'(1);
`ifdef PARIDADE_EN
                  REQ_PAR <= paridade_impar({HH, B});
`endif
               end
            end
            ENVIA: begin
               if (NEG) begin
                  STATUS <= ST_NEGADO;
               end else if (ACK) begin
                  STATUS <= ST_LIBERADO;
               end
            end
            RECUA: begin
               if (tent < TENT_MAX) begin
                  tent <= tent + TW'(1);
               end else begin
                  STATUS <= ST_TEMPO;
               end
            end
            default: ;
         endcase
      end
   end

   // Timer runs only while staying in ENVIA, so every attempt starts from zero.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         timer <= '0;
      end else if (estado == ENVIA && prox == ENVIA) begin
         timer <= timer + TMW'(1);
      end else begin
         timer <= '0;
      end
   end

endmodule

// File: tb/tb_terminal_requisitante_acesso.sv
// Scoreboard bench: stimulus queues expected REQ edges/pulse lengths/final STATUS; a monitor compares.
// Parameters DEB_CYCLES=4, TIMEOUT_CYCLES=8, MAX_RETRY=2.
module tb_terminal_requisitante_acesso;

   localparam int T_UP   = 0;
   localparam int T_DOWN = 1;
   localparam int T_DONE = 2;

   typedef struct {
      int tipo;
      int dado;
   } obs_t;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [3:0] HH = 4'b0000;
   logic [1:0] B = 2'b00;
   logic       BTN_ENVIA = 1'b0;
   logic       ACK = 1'b0;
   logic       NEG = 1'b0;
   logic       REQ;
   logic [3:0] REQ_HH;
   logic [1:0] REQ_B;
   logic       OCUPADO;
   logic [1:0] STATUS;
`ifdef PARIDADE_EN
   logic       REQ_PAR;
`endif

   int   checks = 0;
   int   errors = 0;
   obs_t esperado[$];

   terminal_requisitante_acesso #(
      .DEB_CYCLES     (4),
      .TIMEOUT_CYCLES (8),
      .MAX_RETRY      (2)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .HH        (HH),
      .B         (B),
      .BTN_ENVIA (BTN_ENVIA),
      .ACK       (ACK),
      .NEG       (NEG),
      .REQ       (REQ),
      .REQ_HH    (REQ_HH),
      .REQ_B     (REQ_B),
      .OCUPADO   (OCUPADO),
      .STATUS    (STATUS)
`ifdef PARIDADE_EN
     ,.REQ_PAR   (REQ_PAR)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic verifica(input string nome, input int obtido, input int exigido);
      checks++;
      if (obtido != exigido) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nome, obtido, exigido);
      end
   endtask

   task automatic espera(input int tipo, input int dado);
      obs_t o;
      o.tipo = tipo;
      o.dado = dado;
      esperado.push_back(o);
   endtask

   function automatic string nome_tipo(input int tipo);
      case (tipo)
         T_UP:    return "req_rise_word";
         T_DOWN:  return "req_pulse_len";
         default: return "final_status";
      endcase
   endfunction

   task automatic compara(input int tipo, input int dado);
      obs_t o;
      checks++;
      if (esperado.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got %0d required no event", nome_tipo(tipo), dado);
      end else begin
         o = esperado.pop_front();
         if (o.tipo != tipo || o.dado != dado) begin
            errors++;
            $display("FAIL %s: got %s=%0d required %s=%0d", nome_tipo(o.tipo),
                     nome_tipo(tipo), dado, nome_tipo(o.tipo), o.dado);
         end
`ifdef PARIDADE_EN
         if (tipo == T_UP) begin
            verifica("req_par", int'(REQ_PAR), int'(~^o.dado[5:0]));
         end
`endif
      end
   endtask

   // Monitor: turns DUT activity into observations and checks them against the queue.
   logic req_ant = 1'b0;
   logic ocup_ant = 1'b0;
   int   compr = 0;
   always @(negedge CLK) begin
      if (!RST_N) begin
         req_ant  = 1'b0;
         ocup_ant = 1'b0;
         compr    = 0;
      end else begin
         if (REQ && !req_ant) begin
            compr = 1;
            compara(T_UP, int'({REQ_HH, REQ_B}));
         end else if (REQ) begin
            compr++;
         end else if (!REQ && req_ant) begin
            compara(T_DOWN, compr);
         end
         if (!OCUPADO && ocup_ant) compara(T_DONE, int'(STATUS));
         req_ant  = REQ;
         ocup_ant = OCUPADO;
      end
   end

   // sel 0 waits on REQ, sel 1 waits on OCUPADO; bounded to 60 cycles.
   task automatic aguarda(input int sel, input logic val, input string nome);
      int n = 0;
      logic s;
      s = (sel == 0) ? REQ : OCUPADO;
      while (s !== val && n < 60) begin
         @(negedge CLK);
         n++;
         s = (sel == 0) ? REQ : OCUPADO;
      end
      verifica(nome, int'(s), int'(val));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge CLK);
      verifica("rst_req", int'(REQ), 0);
      verifica("rst_ocupado", int'(OCUPADO), 0);
      verifica("rst_status", int'(STATUS), 0);
      verifica("rst_req_hh", int'(REQ_HH), 0);
      verifica("rst_req_b", int'(REQ_B), 0);
`ifdef PARIDADE_EN
      verifica("rst_req_par", int'(REQ_PAR), 1);
`endif
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);

      // Grant: ACK three cycles after REQ is seen, held two cycles past REQ drop
      HH = 4'b1011;
      B  = 2'b10;
      espera(T_UP, 6'b101110);
      espera(T_DOWN, 4);
      espera(T_DONE, 1);
      fork
         begin
            BTN_ENVIA = 1'b1;
            repeat (10) @(negedge CLK);
            BTN_ENVIA = 1'b0;
         end
      join_none
      aguarda(0, 1'b1, "grant_req_rise");
      repeat (3) @(negedge CLK);
      ACK = 1'b1;
      aguarda(0, 1'b0, "grant_req_fall");
      repeat (2) @(negedge CLK);
      verifica("grant_busy_until_ack_drops", int'(OCUPADO), 1);
      ACK = 1'b0;
      aguarda(1, 1'b0, "grant_idle");
      repeat (12) @(negedge CLK);

      // Bounce: toggling every 2 cycles never holds 4 equal samples
      for (int i = 0; i < 6; i++) begin
         BTN_ENVIA = ~BTN_ENVIA;
         repeat (2) @(negedge CLK);
      end
      BTN_ENVIA = 1'b0;
      repeat (20) @(negedge CLK);
      verifica("bounce_req", int'(REQ), 0);
      verifica("bounce_ocupado", int'(OCUPADO), 0);

      // Deny priority: ACK and NEG together
      HH = 4'b0110;
      B  = 2'b01;
      espera(T_UP, 6'b011001);
      espera(T_DOWN, 1);
      espera(T_DONE, 2);
      fork
         begin
            BTN_ENVIA = 1'b1;
            repeat (10) @(negedge CLK);
            BTN_ENVIA = 1'b0;
         end
      join_none
      aguarda(0, 1'b1, "deny_req_rise");
      ACK = 1'b1;
      NEG = 1'b1;
      aguarda(0, 1'b0, "deny_req_fall");
      repeat (2) @(negedge CLK);
      ACK = 1'b0;
      NEG = 1'b0;
      aguarda(1, 1'b0, "deny_idle");
      repeat (12) @(negedge CLK);

      // Timeout with retry, a second press during ENVIA, switches changed mid-request
      HH = 4'b1011;
      B  = 2'b10;
      espera(T_UP, 6'b101110);
      espera(T_DOWN, 8);
      espera(T_UP, 6'b101110);
      espera(T_DOWN, 8);
      espera(T_DONE, 3);
      fork
         begin
            BTN_ENVIA = 1'b1;
            repeat (7) @(negedge CLK);
            BTN_ENVIA = 1'b0;
            repeat (6) @(negedge CLK);
            BTN_ENVIA = 1'b1;
            repeat (6) @(negedge CLK);
            BTN_ENVIA = 1'b0;
         end
      join_none
      aguarda(0, 1'b1, "timeout_req_rise");
      repeat (2) @(negedge CLK);
      HH = 4'b0000;
      B  = 2'b01;
      aguarda(1, 1'b0, "timeout_idle");
      repeat (15) @(negedge CLK);
      verifica("busy_press_not_queued", int'(REQ), 0);
      verifica("timeout_status_held", int'(STATUS), 3);

      // Reset in the middle of a request
      HH = 4'b1101;
      B  = 2'b11;
      espera(T_UP, 6'b110111);
      fork
         begin
            BTN_ENVIA = 1'b1;
            repeat (10) @(negedge CLK);
            BTN_ENVIA = 1'b0;
         end
      join_none
      aguarda(0, 1'b1, "rstmid_req_rise");
      #2;
      RST_N = 1'b0;
      #1;
      verifica("rstmid_req", int'(REQ), 0);
      verifica("rstmid_status", int'(STATUS), 0);
      verifica("rstmid_ocupado", int'(OCUPADO), 0);
      verifica("rstmid_req_hh", int'(REQ_HH), 0);
`ifdef PARIDADE_EN
      verifica("rstmid_req_par", int'(REQ_PAR), 1);
`endif
      repeat (6) @(negedge CLK);
      RST_N = 1'b1;
      repeat (20) @(negedge CLK);
      verifica("rstmid_no_request", int'(REQ), 0);

      verifica("scoreboard_drained", esperado.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
